// File: rtl/patch_row_reducer_n_pkg.sv
// patch_row_reducer_n_pkg
//   Shared definitions for the parametrised patch row reducer and the config
//   writer that packs its config word.
//   - state_t       : reducer FSM encoding
//   - clog2         : ceiling log2 usable in parameter expressions
//   - owner_width   : owner field width, never below 1 bit
//   - start_col_lsb : bit offset of the start column field
//   - weight_lsb    : bit offset of weight[r][c]
package patch_row_reducer_n_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_COL = 3'd1,
      ST_ACCUM    = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_SUM_RDY  = 3'd4
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic int owner_width(input int n_reducer);
      int w;
      w = clog2(n_reducer);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int start_col_lsb(input int owner_w);
      return owner_w;
   endfunction

   // Weights are packed row-major: all columns of row 0, then row 1, ...
   function automatic int weight_lsb(input int owner_w, input int n_col_size,
                                     input int patch_size, input int fp_size,
                                     input int r, input int c);
      return owner_w + n_col_size + (r * patch_size + c) * fp_size;
   endfunction

endpackage

// File: rtl/patch_row_reducer_n_patch_column_mac.sv
// patch_column_mac
//   Stage 1 of the reducer: N_ROW masked multipliers whose products are
//   registered on the edge that accepts a column beat, plus a valid bit.
//   Ports:
//     dram_clk, reset (async, active-high), flush (sync abort)
//     beat_valid : an accepted beat is present this cycle
//     row_mask   : per-row enable; disabled rows contribute 0
//     pix        : N_ROW pixels, row r at [r*FP_SIZE +: FP_SIZE]
//     weight     : N_ROW weights for the current column, same packing
//     prod       : registered products, row r at [r*2*FP_SIZE +: 2*FP_SIZE]
//     prod_valid : prod holds a beat not yet accumulated
module patch_column_mac #(
   parameter int N_ROW   = 2,
   parameter int FP_SIZE = 16
)(
   input  logic                         dram_clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         beat_valid,
   input  logic [N_ROW-1:0]             row_mask,
   input  logic [N_ROW*FP_SIZE-1:0]     pix,
   input  logic [N_ROW*FP_SIZE-1:0]     weight,
   output logic [N_ROW*2*FP_SIZE-1:0]   prod,
   output logic                         prod_valid
);

   localparam int PROD_W = 2 * FP_SIZE;

   logic [N_ROW*PROD_W-1:0] prod_next;

   always_comb begin
      prod_next = '0;
      for (int r = 0; r < N_ROW; r++) begin
         if (row_mask[r]) begin
            prod_next[r*PROD_W +: PROD_W] =
               PROD_W'(pix[r*FP_SIZE +: FP_SIZE]) * PROD_W'(weight[r*FP_SIZE +: FP_SIZE]);
         end
      end
   end

   always_ff @(posedge dram_clk or posedge reset) begin
      if (reset) begin
         prod       <= '0;
         prod_valid <= 1'b0;
      end else if (flush) begin
         prod_valid <= 1'b0;
      end else begin
         prod_valid <= beat_valid;
         if (beat_valid) begin
            prod <= prod_next;
         end
      end
   end

endmodule

// File: rtl/patch_row_reducer_n.sv
// patch_row_reducer_n
//   Reduces an N_ROW x PATCH_SIZE pixel patch to one weighted sum. Each row
//   is enabled by a mask latched with the config. Column beats are matched
//   against start_col + n_col (wrapping at 2^N_COL_SIZE); non-matching beats
//   are ignored. Two-stage pipeline: masked products (patch_column_mac),
//   then adder tree + accumulate.
//
//   Handshakes: a transfer happens on a rising dram_clk edge where both
//   valid and ready are 1. init_ready is 1 only in IDLE; sum_valid is 1
//   only in SUM_RDY and is a pure function of the state register, so it
//   never depends combinationally on sum_ready. sum/sum_nrow stay stable
//   while sum_valid is high. flush overrides every handshake.
//
//   Ports:
//     dram_clk, reset (async, active-high), flush (sync abort)
//     init_valid/init_ready, row_mask, config_data : config channel
//     l_col, pix_valid, pix                        : column pixel stream
//     owner_reducer, busy                          : status
//     sum_valid/sum_ready, sum, sum_nrow           : result channel
//     fsm_state                                    : FSM state for debug
module patch_row_reducer_n
   import patch_row_reducer_n_pkg::*;
#(
   parameter int APP_DATA_WIDTH        = 256,
   parameter int PATCH_SIZE            = 6,
   parameter int N_ROW                 = 2,
   parameter int N_COL_SIZE            = 12,
   parameter int N_PATCH_REDUCER       = 4,
   parameter int PATCH_REDUCER_INVALID = 0,
   parameter int FP_SIZE               = 16,
   localparam int OWNER_W  = owner_width(N_PATCH_REDUCER),
   localparam int ACC_SIZE = 2 * FP_SIZE + clog2(N_ROW * PATCH_SIZE),
   localparam int NROW_W   = (clog2(N_ROW + 1) < 1) ? 1 : clog2(N_ROW + 1)
)(
   input  logic                       dram_clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       init_valid,
   output logic                       init_ready,
   input  logic [N_ROW-1:0]           row_mask,
   input  logic [APP_DATA_WIDTH-1:0]  config_data,
   input  logic [N_COL_SIZE-1:0]      l_col,
   input  logic                       pix_valid,
   input  logic [N_ROW*FP_SIZE-1:0]   pix,
   output logic [OWNER_W-1:0]         owner_reducer,
   output logic                       busy,
   output logic                       sum_valid,
   input  logic                       sum_ready,
   output logic [ACC_SIZE-1:0]        sum,
   output logic [NROW_W-1:0]          sum_nrow,
   output logic [2:0]                 fsm_state
);

   localparam int PROD_W   = 2 * FP_SIZE;
   localparam int NC_W     = (clog2(PATCH_SIZE + 1) < 1) ? 1 : clog2(PATCH_SIZE + 1);
   localparam int W_BITS   = N_ROW * PATCH_SIZE * FP_SIZE;
   localparam int W_LSB    = weight_lsb(OWNER_W, N_COL_SIZE, PATCH_SIZE, FP_SIZE, 0, 0);
   localparam int CFG_USED = W_LSB + W_BITS;

   state_t                    state, state_next;
   logic [N_COL_SIZE-1:0]     start_col;
   logic [W_BITS-1:0]         weights;
   logic [N_ROW-1:0]          mask_q;
   logic [NC_W-1:0]           n_col;
   logic [ACC_SIZE-1:0]       acc;
   logic [NROW_W-1:0]         nrow_q;
   logic [NROW_W-1:0]         mask_pop;
   logic [N_COL_SIZE-1:0]     exp_col;
   logic                      in_match_state;
   logic                      is_last;
   logic                      beat_accept;
   logic                      init_fire;
   logic                      sum_fire;
   logic [N_ROW*FP_SIZE-1:0]  col_weight;
   logic [N_ROW*PROD_W-1:0]   prod;
   logic                      prod_valid;
   logic [ACC_SIZE-1:0]       tree;

   generate
      if (APP_DATA_WIDTH > CFG_USED) begin : g_cfg_spare
         logic unused_cfg_bits;
         assign unused_cfg_bits = ^config_data[APP_DATA_WIDTH-1:CFG_USED];
      end
   endgenerate

   // Column matching: the expected column wraps naturally at the field width.
   assign exp_col        = start_col + N_COL_SIZE'(n_col);
   assign in_match_state = (state == ST_WAIT_COL) || (state == ST_ACCUM);
   assign is_last        = (n_col == NC_W'(PATCH_SIZE - 1));
   assign beat_accept    = !flush && in_match_state && pix_valid && (l_col == exp_col);
   assign init_fire      = !flush && (state == ST_IDLE) && init_valid;
   assign sum_fire       = !flush && (state == ST_SUM_RDY) && sum_ready;

   // n_col reaches PATCH_SIZE only after the last beat; clamp the select
   // so it never indexes outside the weight store.
   always_comb begin
      int col_idx;
      col_idx    = (int'(n_col) < PATCH_SIZE) ? int'(n_col) : 0;
      col_weight = '0;
      for (int r = 0; r < N_ROW; r++) begin
         col_weight[r*FP_SIZE +: FP_SIZE] = weights[(r*PATCH_SIZE + col_idx)*FP_SIZE +: FP_SIZE];
      end
   end

   always_comb begin
      mask_pop = '0;
      for (int r = 0; r < N_ROW; r++) begin
         mask_pop = mask_pop + NROW_W'(row_mask[r]);
      end
   end

   patch_column_mac #(
      .N_ROW   (N_ROW),
      .FP_SIZE (FP_SIZE)
   ) u_mac (
      .dram_clk   (dram_clk),
      .reset      (reset),
      .flush      (flush),
      .beat_valid (beat_accept),
      .row_mask   (mask_q),
      .pix        (pix),
      .weight     (col_weight),
      .prod       (prod),
      .prod_valid (prod_valid)
   );

   // Stage 2 adder tree across rows.
   always_comb begin
      tree = '0;
      for (int r = 0; r < N_ROW; r++) begin
         tree = tree + ACC_SIZE'(prod[r*PROD_W +: PROD_W]);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (init_valid) state_next = ST_WAIT_COL;
         end
         ST_WAIT_COL, ST_ACCUM: begin
            if (beat_accept) state_next = is_last ? ST_DRAIN : ST_ACCUM;
         end
         // Hold until stage 1 is empty, i.e. the last product has been
         // folded into acc; sum is then final when sum_valid rises.
         ST_DRAIN: begin
            if (!prod_valid) state_next = ST_SUM_RDY;
         end
         ST_SUM_RDY: begin
            if (sum_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (flush) state_next = ST_IDLE;
   end

   always_ff @(posedge dram_clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge dram_clk or posedge reset) begin
      if (reset) begin
         start_col     <= '0;
         weights       <= '0;
         mask_q        <= '0;
         n_col         <= '0;
         acc           <= '0;
         nrow_q        <= '0;
         owner_reducer <= OWNER_W'(PATCH_REDUCER_INVALID);
      end else if (flush) begin
         n_col         <= '0;
         acc           <= '0;
         owner_reducer <= OWNER_W'(PATCH_REDUCER_INVALID);
      end else if (init_fire) begin
         owner_reducer <= config_data[OWNER_W-1:0];
         start_col     <= config_data[start_col_lsb(OWNER_W) +: N_COL_SIZE];
         weights       <= config_data[W_LSB +: W_BITS];
         mask_q        <= row_mask;
         nrow_q        <= mask_pop;
         n_col         <= '0;
         acc           <= '0;
      end else begin
         if (beat_accept) n_col <= n_col + NC_W'(1);
         if (prod_valid)  acc   <= acc + tree;
         if (sum_fire)    owner_reducer <= OWNER_W'(PATCH_REDUCER_INVALID);
      end
   end

   assign init_ready = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign sum_valid  = (state == ST_SUM_RDY);
   assign sum        = acc;
   assign sum_nrow   = nrow_q;
   assign fsm_state  = state;

endmodule
